add16_arbiter: RTL and testbench

- Shares a single `add_16_bit` adder instance among NREQ requesters.
- Round-robin grant, one operation in flight at a time.
- Per-requester valid/ready request ports; one common response channel tagged with the requester id.
- Sits between the requesting engines and the shared 16-bit adder datapath.

---
 rtl/add16_arb_pkg.sv | 35 +++
 rtl/add_16_bit.sv | 11 +
 rtl/rr_picker.sv | 25 ++
 rtl/add16_arbiter.sv | 112 +++++++++++
 tb/tb_add16_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add16_arb_pkg.sv
// Shared types and helpers for the add16 arbiter slice.
// Optional overflow flag output is enabled by defining ADD16_ARB_OVF_EN.
package add16_arb_pkg;

  localparam int WORD_W = 16;
  localparam int MAXREQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Round-robin pick: first set bit after `last`, wrapping modulo n.
  function automatic int rr_pick(
    input logic [MAXREQ-1:0] req,
    input int                n,
    input int                last
  );
    int  g;
    int  idx;
    logic hit;
    g   = 0;
    hit = 1'b0;
    for (int k = 1; k <= MAXREQ; k++) begin
      idx = (last + k) % n;
      if (k <= n && !hit && req[idx[2:0]]) begin
        hit = 1'b1;
        g   = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/add_16_bit.sv
// Shared 16-bit adder datapath.
// Sum wraps modulo 2^16; no carry out.
module add_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Searches from last+1 upward, wrapping modulo NREQ.
module rr_picker
  import add16_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  grant,
  output logic            any
);

  logic [MAXREQ-1:0] req_w;

  // Pad to the helper's fixed width and pick the winner.
  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
    grant            = IDW'(rr_pick(req_w, NREQ, int'(last)));
    any              = |req;
  end

endmodule

// File: rtl/add16_arbiter.sv
// Round-robin arbiter sharing one add_16_bit among NREQ requesters.
// Define ADD16_ARB_OVF_EN to add the registered rsp_ovf output.
module add16_arbiter
  import add16_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
`ifdef ADD16_ARB_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic [WORD_W-1:0]    rsp_sum
);

  arb_state_e        state;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] sum;
  logic [IDW-1:0]    op_id;
  logic [IDW-1:0]    last;
  logic [IDW-1:0]    grant;
  logic              any;
  logic              take;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .last  (last),
    .grant (grant),
    .any   (any)
  );

  add_16_bit u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  assign take = (state == IDLE) && any;

`ifdef ADD16_ARB_OVF_EN
  logic ovf;
  assign ovf = (op_a[15] == op_b[15])
            && (sum[15] != op_a[15]);
`endif

  // Only the picked requester sees ready, and only while idle.
  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant] = 1'b1;
  end

  // Accept -> compute -> hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      last      <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
`ifdef ADD16_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            op_a  <= req_a[grant*WORD_W +: WORD_W];
            op_b  <= req_b[grant*WORD_W +: WORD_W];
            op_id <= grant;
            last  <= grant;
            state <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= sum;
          rsp_id    <= op_id;
`ifdef ADD16_ARB_OVF_EN
          rsp_ovf   <= ovf;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_arbiter.sv
// Self-checking bench for add16_arbiter (NREQ=4).
// Vector table, directed corner sequences, random vs. reference model.
module tb_add16_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_sum;
`ifdef ADD16_ARB_OVF_EN
  logic          rsp_ovf;
`endif

  add16_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ADD16_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #2;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] a,
                                          input logic [15:0] b);
    int s;
    s = int'(a) + int'(b);
    return 16'(s % 65536);
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a,
                                   input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic int ref_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        ovf;
  } vec_t;

  vec_t tbl[7];

  logic [N-1:0] pend;
  logic [15:0]  pa [N];
  logic [15:0]  pb [N];
  int           m_last;
  int           m_due;
  logic         m_busy;
  int           m_id;
  logic [15:0]  m_sum;
  logic         m_ovf;
  int           seen;

  initial begin
    tbl[0] = '{0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
    tbl[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    tbl[2] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    tbl[3] = '{3, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[4] = '{0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{2, 16'hABCD, 16'h1234, 16'hBE01, 1'b0};
    tbl[6] = '{1, 16'h4000, 16'h4000, 16'h8000, 1'b1};

    // Reset values
    do_reset();
    settle();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_sum",   32'(rsp_sum),   32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
`ifdef ADD16_ARB_OVF_EN
    chk("rst_ovf",   32'(rsp_ovf),   32'd0);
`endif
    tick();

    // Single-request vectors, incl. wrap and overflow
    rsp_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      set_op(tbl[v].id, tbl[v].a, tbl[v].b);
      req_valid = 4'(1 << tbl[v].id);
      settle();
      chk("vec_ready", 32'(req_ready), 32'(1 << tbl[v].id));
      tick();
      req_valid = '0;
      settle();
      chk("vec_calc_valid", 32'(rsp_valid), 32'd0);
      tick();
      settle();
      chk("vec_valid", 32'(rsp_valid), 32'd1);
      chk("vec_sum",   32'(rsp_sum),   32'(tbl[v].sum));
      chk("vec_id",    32'(rsp_id),    32'(tbl[v].id));
`ifdef ADD16_ARB_OVF_EN
      chk("vec_ovf",   32'(rsp_ovf),   32'(tbl[v].ovf));
`endif
      tick();
      settle();
      chk("vec_done", 32'(rsp_valid), 32'd0);
    end

    // Contention: all requesting from reset
    do_reset();
    for (int i = 0; i < N; i++)
      set_op(i, 16'(16'h1000 * (i + 1)), 16'(i + 1));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("cont_grant", 32'(req_ready), 32'(1 << (k % N)));
      tick();
      settle();
      chk("cont_calc_ready", 32'(req_ready), 32'd0);
      chk("cont_calc_valid", 32'(rsp_valid), 32'd0);
      tick();
      settle();
      chk("cont_valid", 32'(rsp_valid), 32'd1);
      chk("cont_id",    32'(rsp_id),    32'(k % N));
      chk("cont_sum",   32'(rsp_sum),
          32'(ref_sum(16'(16'h1000 * (k % N + 1)), 16'(k % N + 1))));
      chk("cont_resp_ready", 32'(req_ready), 32'd0);
      tick();
    end

    // Backpressure (pointer now at 0)
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    set_op(1, 16'h0102, 16'h0304);
    settle();
    chk("bp_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1010;
    set_op(3, 16'h1111, 16'h2222);
    tick();
    settle();
    chk("bp_valid0", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      tick();
      settle();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum",   32'(rsp_sum),   32'h0406);
      chk("bp_id",    32'(rsp_id),    32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    settle();
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_grant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick();

    // Reset mid-operation
    do_reset();
    set_op(2, 16'h0005, 16'h0006);
    req_valid = 4'b0100;
    settle();
    chk("mr_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    settle();
    chk("mr_resp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(rsp_valid), 32'd0);
    chk("mr_async_sum",   32'(rsp_sum),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 4'b0100;
    settle();
    chk("mr_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mr_calc_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    settle();
    chk("mr_held_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    req_valid = 4'hF;
    settle();
    chk("mr_post_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick();

    // Withdrawn request
    do_reset();
    rsp_ready = 1'b1;
    set_op(1, 16'h0010, 16'h0001);
    req_valid = 4'b0010;
    settle();
    chk("wd_grant1", 32'(req_ready), 32'b0010);
    tick();
    set_op(2, 16'h0200, 16'h0002);
    set_op(3, 16'h0300, 16'h0003);
    req_valid = 4'b1100;
    settle();
    chk("wd_busy_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 4'b1000;
    settle();
    chk("wd_rsp1_id", 32'(rsp_id), 32'd1);
    tick();
    settle();
    chk("wd_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    seen = 0;
    repeat (6) begin
      settle();
      if (rsp_valid) begin
        seen++;
        chk("wd_rsp_id",  32'(rsp_id),  32'd3);
        chk("wd_rsp_sum", 32'(rsp_sum), 32'h0303);
      end
      tick();
    end
    chk("wd_rsp_count", 32'(seen), 32'd1);

    // Random traffic vs. transaction-level model
    do_reset();
    pend   = '0;
    m_last = N - 1;
    m_busy = 1'b0;
    m_due  = 0;
    m_id   = 0;
    m_sum  = '0;
    m_ovf  = 1'b0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      logic [N-1:0] exp_rdy;
      logic exp_v;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = 16'($urandom);
          pb[i]   = 16'($urandom);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        set_op(i, pa[i], pb[i]);
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      g       = (!m_busy && |pend) ? ref_pick(pend, m_last) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
      exp_v   = m_busy && (cyc >= m_due);
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rnd_id",  32'(rsp_id),  32'(m_id));
        chk("rnd_sum", 32'(rsp_sum), 32'(m_sum));
`ifdef ADD16_ARB_OVF_EN
        chk("rnd_ovf", 32'(rsp_ovf), 32'(m_ovf));
`endif
      end
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_due   = cyc + 2;
        m_id    = g;
        m_sum   = ref_sum(pa[g], pb[g]);
        m_ovf   = ref_ovf(pa[g], pb[g]);
        m_last  = g;
        pend[g] = 1'b0;
      end else if (exp_v && rsp_ready) begin
        m_busy = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
